// File: rtl/vx_cache_reconfig_ctrl_if.sv
// Handshake bundle between the reconfiguration controller, the host/CSR
// configuration port, the core request arbiters and the cache flush port.
interface vx_cache_reconfig_ctrl_if #(
    parameter int NUM_REQS = 4
);
    logic                cfg_valid;
    logic [11:0]         cfg_sets;
    logic                cfg_ready;
    logic                cfg_done;
    logic                cfg_error;
    logic [NUM_REQS-1:0] req_fire;
    logic [NUM_REQS-1:0] rsp_fire;
    logic                req_gate;
    logic                flush_valid;
    logic                flush_ready;
    logic                flush_done;

    // Host / cache-cluster side
    modport master (
        output cfg_valid, cfg_sets, req_fire, rsp_fire, flush_ready, flush_done,
        input  cfg_ready, cfg_done, cfg_error, req_gate, flush_valid
    );

    // Controller side
    modport slave (
        input  cfg_valid, cfg_sets, req_fire, rsp_fire, flush_ready, flush_done,
        output cfg_ready, cfg_done, cfg_error, req_gate, flush_valid
    );
endinterface

// File: rtl/vx_cache_reconfig_ctrl.sv
// Runtime owner of the unified cache set count: gates core traffic, drains
// outstanding requests, flushes the cache and only then commits a new value.
module vx_cache_reconfig_ctrl #(
    parameter int NUM_REQS    = 4,
    parameter int MAX_PENDING = 64,
    parameter int MIN_SETS    = 16,
    parameter int MAX_SETS    = 2048,
    parameter int RESET_SETS  = 256
) (
    input  logic                                 clk,
    input  logic                                 reset,
    vx_cache_reconfig_ctrl_if.slave              bus,
    output logic [11:0]                          unified_cache_sets,
    output logic [$clog2(MAX_PENDING+1)-1:0]     pending_cnt,
    output logic                                 busy
);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_DRAIN,
        S_FLUSH,
        S_WAIT,
        S_COMMIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] next_sets;
    logic        err_q;
    logic        done_q;
    logic        accept;
    logic        legal;
    logic        cnt_over;
    logic        cnt_under;
    logic [CNT_W-1:0] cnt_next;
    int          cnt_sum;

    function automatic int popcnt(input logic [NUM_REQS-1:0] v);
        int n;
        n = 0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    // Legality of the requested set count and the accept strobe
    always_comb begin
        accept = (state == S_IDLE) && bus.cfg_valid;
        legal  = (bus.cfg_sets != '0)
              && ((bus.cfg_sets & (bus.cfg_sets - 12'd1)) == '0)
              && (bus.cfg_sets >= 12'(MIN_SETS))
              && (bus.cfg_sets <= 12'(MAX_SETS));
    end

    // Saturating net in-flight count: requests add, responses subtract
    always_comb begin
        cnt_sum   = int'(pending_cnt) + popcnt(bus.req_fire) - popcnt(bus.rsp_fire);
        cnt_over  = cnt_sum > MAX_PENDING;
        cnt_under = cnt_sum < 0;
        if (cnt_over) begin
            cnt_next = CNT_W'(MAX_PENDING);
        end else if (cnt_under) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    // Next-state and Moore outputs of the reconfiguration sequence
    always_comb begin
        state_next      = state;
        bus.cfg_ready   = (state == S_IDLE);
        bus.req_gate    = (state != S_IDLE);
        bus.flush_valid = (state == S_FLUSH);
        bus.cfg_done    = (state == S_COMMIT) || done_q;
        bus.cfg_error   = err_q;
        busy            = (state != S_IDLE);
        case (state)
            S_IDLE:   if (accept && legal && (bus.cfg_sets != unified_cache_sets)) state_next = S_GATE;
            S_GATE:   state_next = S_DRAIN;
            S_DRAIN:  if ((pending_cnt == '0) && (bus.req_fire == '0)) state_next = S_FLUSH;
            S_FLUSH:  if (bus.flush_ready) state_next = S_WAIT;
            S_WAIT:   if (bus.flush_done) state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending counter register, updated in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_cnt <= '0;
        end else begin
            pending_cnt <= cnt_next;
        end
    end

    // Request outcome pulses, staged target value and committed set count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            unified_cache_sets <= 12'(RESET_SETS);
            next_sets          <= '0;
            err_q              <= 1'b0;
            done_q             <= 1'b0;
        end else begin
            err_q  <= accept && !legal;
            done_q <= accept && legal && (bus.cfg_sets == unified_cache_sets);
            if ((state == S_IDLE) && (state_next == S_GATE)) begin
                next_sets <= bus.cfg_sets;
            end
            if ((state == S_WAIT) && bus.flush_done) begin
                unified_cache_sets <= next_sets;
            end
        end
    end

    // Counter must never leave its range; gated lanes must stay quiet after GATE
    assert property (@(posedge clk) disable iff (!reset) !(cnt_over || cnt_under));
    assert property (@(posedge clk) disable iff (!reset)
        !(((state == S_DRAIN) || (state == S_FLUSH) || (state == S_WAIT) || (state == S_COMMIT))
          && (bus.req_fire != '0)));
endmodule

// File: tb/tb_vx_cache_reconfig_ctrl.sv
// Self-checking bench for vx_cache_reconfig_ctrl: directed and randomized
// reconfiguration requests checked against a transaction-level model.
module tb_vx_cache_reconfig_ctrl;
    logic        clk;
    logic        reset;
    logic [11:0] sets;
    logic [6:0]  pending_cnt;
    logic        busy;

    int          n_cmp;
    int          n_bad;
    int          exp_pending;
    logic [11:0] exp_sets;

    vx_cache_reconfig_ctrl_if #(.NUM_REQS(4)) bus ();

    vx_cache_reconfig_ctrl #(
        .NUM_REQS(4), .MAX_PENDING(64), .MIN_SETS(16), .MAX_SETS(2048), .RESET_SETS(256)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .unified_cache_sets(sets),
        .pending_cnt(pending_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic bit is_legal(input logic [11:0] v);
        for (int k = 4; k <= 11; k++) begin
            if (int'(v) == (1 << k)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: model absorbs the lane activity presented at this edge
    task automatic cyc();
        int s;
        @(posedge clk);
        if (reset) begin
            s = exp_pending + $countones(bus.req_fire) - $countones(bus.rsp_fire);
            exp_pending = (s > 64) ? 64 : ((s < 0) ? 0 : s);
        end
        #1;
    endtask

    task automatic traffic(input logic [3:0] req, input logic [3:0] rsp);
        bus.req_fire = req;
        bus.rsp_fire = rsp;
        cyc();
        bus.req_fire = '0;
        bus.rsp_fire = '0;
        chk("idle_cnt", pending_cnt, exp_pending);
    endtask

    task automatic drain_idle();
        while (exp_pending != 0) traffic(4'b0000, 4'b0001 << $urandom_range(0, 3));
    endtask

    task automatic do_cfg(input logic [11:0] s, input bit gate_req, input int rsp_delay,
                          input int rdy_delay, input int done_delay);
        int waited;
        bus.cfg_valid = 1'b1;
        bus.cfg_sets  = s;
        cyc();
        bus.cfg_valid = 1'b0;
        if (!is_legal(s)) begin
            chk("err_pulse", bus.cfg_error, 1);
            chk("err_nodone", bus.cfg_done, 0);
            chk("err_nogate", bus.req_gate, 0);
            chk("err_sets", sets, exp_sets);
            cyc();
            chk("err_clear", bus.cfg_error, 0);
            chk("err_idle", busy, 0);
        end else if (s == exp_sets) begin
            chk("eq_done", bus.cfg_done, 1);
            chk("eq_nogate", bus.req_gate, 0);
            cyc();
            chk("eq_clear", bus.cfg_done, 0);
            chk("eq_noflush", bus.flush_valid, 0);
            chk("eq_sets", sets, exp_sets);
        end else begin
            chk("gate_rise", bus.req_gate, 1);
            chk("gate_busy", busy, 1);
            chk("gate_noready", bus.cfg_ready, 0);
            chk("gate_noflush", bus.flush_valid, 0);
            if (gate_req) bus.req_fire = 4'b0001 << $urandom_range(0, 3);
            cyc();
            bus.req_fire = '0;
            chk("drain_noflush", bus.flush_valid, 0);
            chk("drain_cnt", pending_cnt, exp_pending);
            waited = 0;
            while (exp_pending != 0) begin
                bus.rsp_fire = (waited >= rsp_delay) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
                cyc();
                bus.rsp_fire = '0;
                waited++;
                chk("drain_hold", bus.flush_valid, 0);
                chk("drain_cnt", pending_cnt, exp_pending);
            end
            cyc();
            chk("flush_rise", bus.flush_valid, 1);
            chk("flush_gate", bus.req_gate, 1);
            for (int i = 0; i < rdy_delay; i++) begin
                bus.flush_done = (i == 0);
                cyc();
                bus.flush_done = 1'b0;
                chk("flush_hold", bus.flush_valid, 1);
            end
            bus.flush_ready = 1'b1;
            cyc();
            bus.flush_ready = 1'b0;
            chk("wait_noflush", bus.flush_valid, 0);
            chk("wait_gate", bus.req_gate, 1);
            chk("wait_sets", sets, exp_sets);
            for (int i = 0; i < done_delay; i++) begin
                cyc();
                chk("wait_sets", sets, exp_sets);
                chk("wait_nodone", bus.cfg_done, 0);
            end
            bus.flush_done = 1'b1;
            cyc();
            bus.flush_done = 1'b0;
            exp_sets = s;
            chk("commit_sets", sets, exp_sets);
            chk("commit_done", bus.cfg_done, 1);
            chk("commit_gate", bus.req_gate, 1);
            cyc();
            chk("reopen_gate", bus.req_gate, 0);
            chk("reopen_done", bus.cfg_done, 0);
            chk("reopen_ready", bus.cfg_ready, 1);
            chk("reopen_busy", busy, 0);
        end
    endtask

    initial begin
        logic [11:0] v;
        logic [11:0] abort_sets;
        int          kind;
        n_cmp = 0;
        n_bad = 0;
        exp_pending = 0;
        exp_sets = 12'd256;
        bus.cfg_valid   = 1'b0;
        bus.cfg_sets    = '0;
        bus.req_fire    = '0;
        bus.rsp_fire    = '0;
        bus.flush_ready = 1'b0;
        bus.flush_done  = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cyc();

        chk("rst_sets", sets, 256);
        chk("rst_ready", bus.cfg_ready, 1);
        chk("rst_gate", bus.req_gate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", pending_cnt, 0);
        chk("rst_flush", bus.flush_valid, 0);
        chk("rst_done", bus.cfg_done, 0);
        chk("rst_err", bus.cfg_error, 0);

        // Basic change with nothing pending, flush_done 5 cycles after handshake
        do_cfg(12'd512, 1'b0, 0, 0, 4);

        // Three requests outstanding, responses start 10 cycles into drain
        traffic(4'b0111, 4'b0000);
        do_cfg(12'd1024, 1'b0, 10, 1, 2);

        // Same-cycle request and response net out
        traffic(4'b0011, 4'b0000);
        traffic(4'b0011, 4'b0100);
        drain_idle();

        // Illegal values, then equal-to-current, then range limits
        do_cfg(12'd300, 1'b0, 0, 0, 0);
        do_cfg(12'd8, 1'b0, 0, 0, 0);
        do_cfg(12'd4095, 1'b0, 0, 0, 0);
        do_cfg(12'd0, 1'b0, 0, 0, 0);
        do_cfg(12'd1024, 1'b0, 0, 0, 0);
        do_cfg(12'd256, 1'b1, 0, 2, 0);
        do_cfg(12'd256, 1'b0, 0, 0, 0);
        do_cfg(12'd16, 1'b0, 0, 0, 1);
        do_cfg(12'd2048, 1'b1, 3, 0, 0);

        // Randomized mix
        for (int it = 0; it < 12; it++) begin
            for (int p = $urandom_range(0, 3); p > 0; p--) begin
                traffic(4'($urandom_range(0, 15)),
                        (exp_pending > 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000);
            end
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 0) v = 12'($urandom_range(17, 2047)) | 12'd1;
                else v = 12'd1 << $urandom_range(0, 3);
            end else if (kind == 1) begin
                v = exp_sets;
            end else begin
                do v = 12'd1 << $urandom_range(4, 11); while (v == exp_sets);
            end
            do_cfg(v, 1'($urandom_range(0, 1)), $urandom_range(0, 6),
                   $urandom_range(0, 3), $urandom_range(0, 6));
        end

        // Reset while waiting for flush completion
        drain_idle();
        abort_sets = (exp_sets == 12'd128) ? 12'd64 : 12'd128;
        bus.flush_ready = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_sets  = abort_sets;
        cyc();
        bus.cfg_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        bus.flush_ready = 1'b0;
        chk("abort_in_wait", busy, 1);
        chk("abort_wait_noflush", bus.flush_valid, 0);
        #2 reset = 1'b0;
        #1;
        exp_sets = 12'd256;
        exp_pending = 0;
        chk("abort_sets", sets, exp_sets);
        chk("abort_busy", busy, 0);
        chk("abort_flush", bus.flush_valid, 0);
        chk("abort_gate", bus.req_gate, 0);
        chk("abort_cnt", pending_cnt, 0);
        chk("abort_done", bus.cfg_done, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.flush_done = 1'b1;
        cyc();
        bus.flush_done = 1'b0;
        cyc();
        chk("post_abort_done", bus.cfg_done, 0);
        chk("post_abort_sets", sets, exp_sets);
        chk("post_abort_ready", bus.cfg_ready, 1);
        do_cfg(abort_sets, 1'b0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
